lfsr_rr_scheduler: RTL and testbench

Owns one 7-bit Fibonacci LFSR (taps bits 6 and 5, polynomial x^7+x^6+1, period 127) and shares it among NREQ requesters. Arbitration is round-robin, and each winner receives a burst of parity-tagged 8-bit words over a valid/ready stream. The block also handles seed configuration, with lockup protection.

---
 rtl/lfsr_rr_scheduler.sv | 128 ++++++++++++
 tb/tb_lfsr_rr_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rr_scheduler.sv
// Round-robin scheduler sharing one x^7+x^6+1 LFSR among NREQ requesters.
// Each grant streams a burst of parity-tagged LFSR words over valid/ready.
module lfsr_rr_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned BURST_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seed_wr,
  input  logic [6:0]              seed_data,
  input  logic [NREQ-1:0]         req,
  input  logic [BURST_W-1:0]      burst_len,
  output logic [NREQ-1:0]         gnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_data,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic                    out_last,
  output logic                    busy,
  output logic [6:0]              lfsr_state
);

  localparam int unsigned IdW = $clog2(NREQ);
  localparam int unsigned CntW = BURST_W + 1;

  typedef enum logic {StIdle, StStream} state_e;

  state_e            state_q, state_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic              found;
  logic [IdW-1:0]    winner;
  logic [IdW:0]      cand;
  logic [6:0]        lfsr_next;
  logic [IdW-1:0]    rr_after;
  logic              xfer;

  // Search upward from rr_ptr, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdW + 1)'(i);
      if (cand >= (IdW + 1)'(NREQ)) begin
        cand = cand - (IdW + 1)'(NREQ);
      end
      if (!found && req[cand[IdW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdW-1:0];
      end
    end
  end

  assign lfsr_next = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  assign rr_after  = (id_q == IdW'(NREQ - 1)) ? '0 : id_q + IdW'(1);

  // A dropped request kills the word in the same cycle, so valid is gated by req.
  assign out_valid  = (state_q == StStream) && req[id_q];
  assign xfer       = out_valid && out_ready;
  assign out_last   = (state_q == StStream) && (count_q == CntW'(1));
  assign busy       = (state_q == StStream);
  assign out_data   = {~(^lfsr_q), lfsr_q};
  assign out_id     = id_q;
  assign gnt        = gnt_q;
  assign lfsr_state = lfsr_q;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    count_d  = count_q;
    gnt_d    = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (seed_wr) begin
          lfsr_d = (seed_data == 7'h00) ? 7'h01 : seed_data;
        end else if (found) begin
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          id_d          = winner;
          count_d       = (burst_len == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, burst_len};
          state_d       = StStream;
        end
      end
      StStream: begin
        if (!req[id_q]) begin
          state_d  = StIdle;
          gnt_d    = '0;
          rr_ptr_d = rr_after;
        end else if (xfer) begin
          lfsr_d  = lfsr_next;
          count_d = count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            state_d  = StIdle;
            gnt_d    = '0;
            rr_ptr_d = rr_after;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lfsr_q   <= 7'h01;
      rr_ptr_q <= '0;
      id_q     <= '0;
      count_q  <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      count_q  <= count_d;
      gnt_q    <= gnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Directed bench for lfsr_rr_scheduler: inputs change and outputs are sampled on negedge.
module tb_lfsr_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_wr;
  logic [6:0] seed_data;
  logic [3:0] req;
  logic [3:0] burst_len;
  logic [3:0] gnt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_id;
  logic       out_last;
  logic       busy;
  logic [6:0] lfsr_state;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_lfsr;
  logic [7:0] exp_words [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'hC1, 8'h83};
  logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  lfsr_rr_scheduler #(
    .NREQ   (4),
    .BURST_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_wr   (seed_wr),
    .seed_data (seed_data),
    .req       (req),
    .burst_len (burst_len),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .busy      (busy),
    .lfsr_state(lfsr_state)
  );

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  function automatic logic [7:0] word_of(input logic [6:0] s);
    return {~(^s), s};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b exp 0000", gnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b exp 0", out_last); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", out_id); end
    checks++; if (lfsr_state !== 7'h01) begin errors++; $display("FAIL rst_lfsr got %h exp 01", lfsr_state); end
    rst = 1'b0;
  endtask

  task automatic test_burst8();
    req = 4'b0001; burst_len = 4'd8; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL b8_gnt got %b exp 0001", gnt); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL b8_id got %0d exp 0", out_id); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b8_valid[%0d] got %b exp 1", k, out_valid); end
      checks++; if (out_data !== exp_words[k]) begin
        errors++; $display("FAIL b8_data[%0d] got %h exp %h", k, out_data, exp_words[k]);
      end
      checks++; if (out_last !== (k == 7)) begin
        errors++; $display("FAIL b8_last[%0d] got %b exp %b", k, out_last, (k == 7));
      end
      @(negedge clk);
    end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL b8_gnt_end got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b8_busy_end got %b exp 0", busy); end
    checks++; if (lfsr_state !== 7'h06) begin errors++; $display("FAIL b8_lfsr_end got %h exp 06", lfsr_state); end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b1111; burst_len = 4'd1; out_ready = 1'b1;
    exp_lfsr = 7'h01;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (gnt !== (4'b0001 << (k % 4))) begin
        errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, 4'b0001 << (k % 4));
      end
      checks++; if (out_id !== 2'(k % 4)) begin
        errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", k, out_id, k % 4);
      end
      checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rr_last[%0d] got %b exp 1", k, out_last); end
      checks++; if (out_data !== word_of(exp_lfsr)) begin
        errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, out_data, word_of(exp_lfsr));
      end
      exp_lfsr = lfsr_step(exp_lfsr);
      @(negedge clk);
      checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin
        errors++; $display("FAIL rr_gap[%0d] got busy=%b gnt=%b exp 0/0000", k, busy, gnt);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_seed();
    seed_wr = 1'b1; seed_data = 7'h00; req = 4'b0001; burst_len = 4'd1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (lfsr_state !== 7'h01) begin errors++; $display("FAIL seed0_lfsr got %h exp 01", lfsr_state); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL seed0_gnt got %b exp 0000", gnt); end
    seed_wr = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL seed0_grant got %b exp 0001", gnt); end
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL seed0_data got %h exp 01", out_data); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL seed_idle got %b exp 0", busy); end
    seed_wr = 1'b1; seed_data = 7'h55;
    @(negedge clk);
    checks++; if (lfsr_state !== 7'h55) begin errors++; $display("FAIL seed55_lfsr got %h exp 55", lfsr_state); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL seed55_gnt got %b exp 0000", gnt); end
    seed_wr = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL seed55_grant got %b exp 0001", gnt); end
    checks++; if (out_data !== 8'hD5) begin errors++; $display("FAIL seed55_data got %h exp d5", out_data); end
    @(negedge clk);
    checks++; if (lfsr_state !== 7'h2B) begin errors++; $display("FAIL seed55_next got %h exp 2b", lfsr_state); end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    int xfers;
    seed_wr = 1'b1; seed_data = 7'h01;
    @(negedge clk);
    seed_wr = 1'b0; req = 4'b0001; burst_len = 4'd4; out_ready = 1'b0;
    @(negedge clk);
    exp_lfsr = 7'h01;
    xfers = 0;
    for (int j = 0; j < 7; j++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", j, out_valid); end
      checks++; if (out_data !== word_of(exp_lfsr)) begin
        errors++; $display("FAIL bp_data[%0d] got %h exp %h", j, out_data, word_of(exp_lfsr));
      end
      checks++; if (lfsr_state !== exp_lfsr) begin
        errors++; $display("FAIL bp_lfsr[%0d] got %h exp %h", j, lfsr_state, exp_lfsr);
      end
      checks++; if (out_last !== (xfers == 3)) begin
        errors++; $display("FAIL bp_last[%0d] got %b exp %b", j, out_last, (xfers == 3));
      end
      out_ready = pat[j];
      @(negedge clk);
      if (pat[j]) begin
        exp_lfsr = lfsr_step(exp_lfsr);
        xfers++;
      end
    end
    checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL bp_end got busy=%b gnt=%b exp 0/0000", busy, gnt);
    end
    checks++; if (lfsr_state !== 7'h10) begin errors++; $display("FAIL bp_lfsr_end got %h exp 10", lfsr_state); end
    req = 4'b0000; out_ready = 1'b0;
  endtask

  task automatic test_full_period();
    int words;
    seed_wr = 1'b1; seed_data = 7'h01; req = 4'b0001; burst_len = 4'd0; out_ready = 1'b1;
    @(negedge clk);
    seed_wr = 1'b0;
    exp_lfsr = 7'h01;
    words = 0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      checks++; if (gnt !== 4'b0001 || busy !== 1'b1) begin
        errors++; $display("FAIL fp_grant[%0d] got gnt=%b busy=%b exp 0001/1", b, gnt, busy);
      end
      for (int w = 0; w < 16; w++) begin
        if (words == 127) begin
          checks++; if (lfsr_state !== 7'h01) begin
            errors++; $display("FAIL fp_period got %h exp 01", lfsr_state);
          end
        end
        checks++; if (lfsr_state === 7'h00) begin
          errors++; $display("FAIL fp_lockup[%0d] got 00 exp nonzero", words);
        end
        checks++; if (out_data !== word_of(exp_lfsr)) begin
          errors++; $display("FAIL fp_data[%0d] got %h exp %h", words, out_data, word_of(exp_lfsr));
        end
        checks++; if (out_last !== (w == 15)) begin
          errors++; $display("FAIL fp_last[%0d] got %b exp %b", words, out_last, (w == 15));
        end
        @(negedge clk);
        exp_lfsr = lfsr_step(exp_lfsr);
        words++;
      end
      checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin
        errors++; $display("FAIL fp_end[%0d] got busy=%b gnt=%b exp 0/0000", b, busy, gnt);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_abort_and_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b0011; burst_len = 4'd8; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ab_gnt got %b exp 0001", gnt); end
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL ab_w0 got %h exp 01", out_data); end
    @(negedge clk);
    checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL ab_w1 got %h exp 02", out_data); end
    @(negedge clk);
    req = 4'b0010;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ab_valid got %b exp 0", out_valid); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL ab_idle got gnt=%b busy=%b exp 0000/0", gnt, busy);
    end
    checks++; if (lfsr_state !== 7'h04) begin errors++; $display("FAIL ab_lfsr got %h exp 04", lfsr_state); end
    req = 4'b0011;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ab_rr_gnt got %b exp 0010", gnt); end
    checks++; if (out_id !== 2'd1) begin errors++; $display("FAIL ab_rr_id got %0d exp 1", out_id); end
    checks++; if (out_data !== 8'h04) begin errors++; $display("FAIL ab_rr_data got %h exp 04", out_data); end
    @(negedge clk);
    checks++; if (lfsr_state !== 7'h08) begin errors++; $display("FAIL mr_pre got %h exp 08", lfsr_state); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mr_gnt got %b exp 0000", gnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b exp 0", busy); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL mr_last got %b exp 0", out_last); end
    checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL mr_id got %0d exp 0", out_id); end
    checks++; if (lfsr_state !== 7'h01) begin errors++; $display("FAIL mr_lfsr got %h exp 01", lfsr_state); end
    rst = 1'b0; req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; seed_wr = 1'b0; seed_data = 7'h00; req = 4'b0000;
    burst_len = 4'd0; out_ready = 1'b0;
    test_reset();
    test_burst8();
    test_round_robin();
    test_seed();
    test_backpressure();
    test_full_period();
    test_abort_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
